// File: rtl/serial_max_pkg.sv
// Shared types and helpers for the serial_max bit-serial comparator.
// Optional min_out is enabled by defining SERIAL_MAX_MIN_EN.
package serial_max_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EQ   = 2'd1,
      A_GT = 2'd2,
      B_GT = 2'd3
   } state_t;

   localparam int WIDTH_DEFAULT = 4;

   // Bits needed to hold values 0..value-1 (at least 1).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_max_if.sv
// Handshake and result bundle for serial_max.
// min_out exists only when SERIAL_MAX_MIN_EN is defined.
interface serial_max_if
   import serial_max_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   logic             start;
   logic             a_bit;
   logic             b_bit;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] max_out;
   logic             a_gt_b;
   logic             a_eq_b;
`ifdef SERIAL_MAX_MIN_EN
   logic [WIDTH-1:0] min_out;
`endif

   modport master (
      output start, a_bit, b_bit,
`ifdef SERIAL_MAX_MIN_EN
      input  min_out,
`endif
      input  busy, done, max_out, a_gt_b, a_eq_b
   );

   modport slave (
      input  start, a_bit, b_bit,
`ifdef SERIAL_MAX_MIN_EN
      output min_out,
`endif
      output busy, done, max_out, a_gt_b, a_eq_b
   );
endinterface

// File: rtl/serial_max_fsm.sv
// Comparison FSM and bit counter for serial_max; exposes the decision that
// includes the bit pair currently on the inputs so results can be registered on the last bit.
//
//   state | meaning
//   IDLE  | waiting for start
//   EQ    | all bits so far equal
//   A_GT  | A already known greater (sticky)
//   B_GT  | B already known greater (sticky)
module serial_max_fsm
   import serial_max_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   input  logic   a_bit,
   input  logic   b_bit,
   output state_t state,
   output state_t decided,
   output logic   shift,
   output logic   last
);
   localparam int CW = clog2(WIDTH);

   state_t        state_nxt;
   state_t        base;
   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      shift     = 1'b0;
      last      = 1'b0;
      base      = (state == IDLE) ? EQ : state;
      decided   = base;
      if (base == EQ) begin
         if (a_bit && !b_bit)      decided = A_GT;
         else if (!a_bit && b_bit) decided = B_GT;
      end
      case (state)
         IDLE: begin
            if (start) begin
               shift     = 1'b1;
               state_nxt = decided;
               cnt_nxt   = CW'(WIDTH - 1);
            end
         end
         default: begin
            shift   = 1'b1;
            cnt_nxt = bit_cnt - CW'(1);
            if (bit_cnt == CW'(1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = decided;
            end
         end
      endcase
   end
endmodule

// File: rtl/serial_max.sv
// Bit-serial unsigned max of two MSB-first operands; shift and result registers.
// Define SERIAL_MAX_MIN_EN to also produce min_out.
module serial_max
   import serial_max_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input logic      clk,
   input logic      rst_n,
   serial_max_if.slave bus
);
   state_t           state;
   state_t           decided;
   logic             shift;
   logic             last;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] a_full;
   logic [WIDTH-1:0] b_full;
   logic [WIDTH-1:0] max_q;
   logic             done_q;
   logic             gt_q;
   logic             eq_q;
`ifdef SERIAL_MAX_MIN_EN
   logic [WIDTH-1:0] min_q;
`endif

   serial_max_fsm #(.WIDTH(WIDTH)) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (bus.start),
      .a_bit   (bus.a_bit),
      .b_bit   (bus.b_bit),
      .state   (state),
      .decided (decided),
      .shift   (shift),
      .last    (last)
   );

   // Operand values including the bit pair currently on the inputs.
   assign a_full = {a_sr[WIDTH-2:0], bus.a_bit};
   assign b_full = {b_sr[WIDTH-2:0], bus.b_bit};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         max_q  <= '0;
         done_q <= 1'b0;
         gt_q   <= 1'b0;
         eq_q   <= 1'b0;
`ifdef SERIAL_MAX_MIN_EN
         min_q  <= '0;
`endif
      end else begin
         done_q <= last;
         if (shift) begin
            a_sr <= a_full;
            b_sr <= b_full;
         end
         if (last) begin
            max_q <= (decided == B_GT) ? b_full : a_full;
            gt_q  <= (decided == A_GT);
            eq_q  <= (decided == EQ);
`ifdef SERIAL_MAX_MIN_EN
            min_q <= (decided == B_GT) ? a_full : b_full;
`endif
         end
      end
   end

   // An accepted start counts as busy in its own cycle, so back-to-back runs keep busy high.
   assign bus.busy    = (state != IDLE) || (bus.start && rst_n);
   assign bus.done    = done_q;
   assign bus.max_out = max_q;
   assign bus.a_gt_b  = gt_q;
   assign bus.a_eq_b  = eq_q;
`ifdef SERIAL_MAX_MIN_EN
   assign bus.min_out = min_q;
`endif
endmodule

// File: doc/serial_max.md
SERIAL_MAX -- requirements
Module: serial_max

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  begins a comparison; the MSB pair is presented on a_bit/b_bit in the same cycle.
REQ-005 a_bit  input  1  serial operand A, MSB first.
REQ-006 b_bit  input  1  serial operand B, MSB first.
REQ-007 busy  output  1  high while a comparison is in progress.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 max_out  output  WIDTH  max(A,B), unsigned; held from done until the next done.
REQ-010 a_gt_b  output  1  A > B for the last completed comparison.
REQ-011 a_eq_b  output  1  A == B for the last completed comparison.

Function
REQ-012 The FSM SHALL have the states IDLE, EQ, A_GT and B_GT.
REQ-013 IDLE with start=1: the block SHALL shift in the MSB pair, move to EQ/A_GT/B_GT by comparing that pair, load bit_cnt=WIDTH-1 and set busy.
REQ-014 Each busy cycle SHALL shift one bit of A and one bit of B into the A and B shift registers (MSB first) and decrement bit_cnt.
REQ-015 From EQ, the transitions SHALL be: a_bit>b_bit -> A_GT, a_bit<b_bit -> B_GT, a_bit==b_bit -> stay in EQ.
REQ-016 A_GT and B_GT SHALL be sticky until the comparison completes.
REQ-017 When the last bit is shifted (bit_cnt==1 while busy), the next cycle SHALL assert done, deassert busy, register the results and return the FSM to IDLE.
REQ-018 Latency: start in cycle k -> done in cycle k+WIDTH (k+4 for WIDTH=4); the bit pairs SHALL be sampled in cycles k..k+WIDTH-1.
REQ-019 The registered results SHALL be: max_out = B if B_GT, otherwise A (A is returned when A==B); a_gt_b = (state==A_GT); a_eq_b = (state==EQ).
REQ-020 start while busy SHALL be ignored, with no restart and no error.
REQ-021 start in the same cycle as done SHALL be accepted, giving back-to-back comparisons with no idle cycle.
REQ-022 a_bit/b_bit SHALL be don't-care while not busy and not starting.
REQ-023 Unsigned compare only; no sign handling.

Reset
REQ-024 rst_n=0 at a clock edge SHALL clear: FSM=IDLE, bit_cnt=0, busy=0, done=0, max_out=0, a_gt_b=0, a_eq_b=0, both shift registers=0.
REQ-025 Reset during a comparison SHALL abort it with no done pulse; the old result is lost.
REQ-026 rst_n has priority over start.

Configuration
REQ-027 Macro SERIAL_MAX_MIN_EN defined: a min_out output (WIDTH bits) SHALL be added, equal to the operand not chosen as max, updated and reset together with max_out.
REQ-028 Macro SERIAL_MAX_MIN_EN undefined: min_out port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package serial_max_pkg SHALL hold: the state typedef (IDLE, EQ, A_GT, B_GT), WIDTH_DEFAULT=4, and a counter-width function clog2(WIDTH).
REQ-030 One sub-module, serial_max_fsm (state register, next-state logic, bit_cnt), SHALL be used; the datapath (shift registers, result registers) stays in serial_max.

Verification
REQ-031 A=0100, B=1000 (WIDTH=4) -> done at start+4, max_out=1000, a_gt_b=0, a_eq_b=0.
REQ-032 A=1100, B=1010 -> max_out=1100, a_gt_b=1; the FSM decides in the 2nd bit cycle and stays in A_GT.
REQ-033 A=B=0001 -> max_out=0001, a_eq_b=1, a_gt_b=0.
REQ-034 Back-to-back: start at k (A=1001, B=0111), then start at k+4 (A=1011, B=1101) -> done at k+4 and k+8, max_out 1001 then 1101, busy high continuously.
REQ-035 start pulsed at k+2 during an active comparison -> ignored; a single done at k+4 with the correct result.
REQ-036 rst_n=0 at k+2 mid-comparison -> no done; all outputs 0 next cycle; a new start after reset gives a correct result; with SERIAL_MAX_MIN_EN, A=1001, B=0000 -> min_out=0000.
